// File: rtl/jtframe_vtimer_gen.sv
// Video timing generator: fractional N/M pixel clock enables, H/V counters,
// blanking, sync with frame-latched centring offsets and a frame counter.
module jtframe_vtimer_gen #(
  parameter int HW       = 9,
  parameter int CW       = 4,
  parameter int CEN_N    = 1,
  parameter int CEN_M    = 4,
  parameter int H_START  = 0,
  parameter int H_END    = 383,
  parameter int HB_START = 255,
  parameter int HB_END   = 383,
  parameter int HS_START = 297,
  parameter int HS_LEN   = 32,
  parameter int V_START  = 16,
  parameter int V_END    = 279,
  parameter int VB_START = 239,
  parameter int VB_END   = 279,
  parameter int VS_START = 254,
  parameter int VS_LEN   = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [3:0]    hoffset,
  input  logic [3:0]    voffset,
  output logic          pxl2_cen,
  output logic          pxl_cen,
  output logic [HW-1:0] H,
  output logic [HW-1:0] vdump,
  output logic [HW-1:0] vrender,
  output logic [HW-1:0] vrender1,
  output logic          Hinit,
  output logic          Vinit,
  output logic          LHBL,
  output logic          LVBL,
  output logic          HS,
  output logic          VS,
  output logic [7:0]    frame_cnt
);
  localparam int CW1 = CW + 1;
  localparam logic [CW:0]   CEN_N_W    = CW1'(CEN_N);
  localparam logic [CW:0]   CEN_M_W    = CW1'(CEN_M);
  localparam logic [HW-1:0] H_START_W  = HW'(H_START);
  localparam logic [HW-1:0] H_END_W    = HW'(H_END);
  localparam logic [HW-1:0] HB_START_W = HW'(HB_START);
  localparam logic [HW-1:0] HB_END_W   = HW'(HB_END);
  localparam logic [HW-1:0] HS_START_W = HW'(HS_START);
  localparam logic [HW-1:0] V_START_W  = HW'(V_START);
  localparam logic [HW-1:0] V_END_W    = HW'(V_END);
  localparam logic [HW-1:0] VB_START_W = HW'(VB_START);
  localparam logic [HW-1:0] VB_END_W   = HW'(VB_END);
  localparam logic [HW-1:0] VS_START_W = HW'(VS_START);
  localparam logic [15:0]   HS_LEN_M1  = 16'(HS_LEN - 1);
  localparam logic [15:0]   VS_LEN_M1  = 16'(VS_LEN - 1);
  localparam bit            HS_EN      = HS_LEN > 0;
  localparam bit            VS_EN      = VS_LEN > 0;

  logic [CW-1:0] acc_q;
  logic [CW:0]   sum;
  logic          toggle_q, pxl2_cen_q, pxl_cen_q;

  logic [HW-1:0] h_q, h_d, vdump_q, vdump_d, vrender_q, vrender_d, vrender1_q, vrender1_d;
  logic          hinit_q, hinit_d, vinit_q, vinit_d;
  logic          lhbl_q, lhbl_d, lvbl_q, lvbl_d;
  logic          hs_q, hs_d, vs_q, vs_d;
  logic [15:0]   hs_cnt_q, hs_cnt_d, vs_cnt_q, vs_cnt_d;
  logic [7:0]    frame_cnt_q, frame_cnt_d;
  logic [3:0]    hoff_q, hoff_d, voff_q, voff_d;
  logic [HW-1:0] hs_pos, vs_pos;
  logic          hs_hit;

  function automatic logic [HW-1:0] line_inc(input logic [HW-1:0] v);
    return (v == V_END_W) ? V_START_W : v + HW'(1);
  endfunction

  // Fractional enable: accumulate N per clock, fire and subtract M on overflow
  assign sum = {1'b0, acc_q} + CEN_N_W;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q      <= '0;
      toggle_q   <= 1'b0;
      pxl2_cen_q <= 1'b0;
      pxl_cen_q  <= 1'b0;
    end else if (sum >= CEN_M_W) begin
      acc_q      <= CW'(sum - CEN_M_W);
      toggle_q   <= ~toggle_q;
      pxl2_cen_q <= 1'b1;
      pxl_cen_q  <= toggle_q;
    end else begin
      acc_q      <= sum[CW-1:0];
      pxl2_cen_q <= 1'b0;
      pxl_cen_q  <= 1'b0;
    end
  end

  // Flags describe the pixel being entered, so all compares use the next H/V
  always_comb begin
    h_d         = h_q;
    vdump_d     = vdump_q;
    vrender_d   = vrender_q;
    vrender1_d  = vrender1_q;
    hinit_d     = hinit_q;
    vinit_d     = vinit_q;
    lhbl_d      = lhbl_q;
    lvbl_d      = lvbl_q;
    hs_d        = hs_q;
    hs_cnt_d    = hs_cnt_q;
    vs_d        = vs_q;
    vs_cnt_d    = vs_cnt_q;
    frame_cnt_d = frame_cnt_q;
    hoff_d      = hoff_q;
    voff_d      = voff_q;
    hs_hit      = 1'b0;
    hs_pos      = HS_START_W + {{(HW-4){hoff_q[3]}}, hoff_q};
    vs_pos      = VS_START_W + {{(HW-4){voff_q[3]}}, voff_q};
    if (pxl_cen_q) begin
      h_d = (h_q == H_END_W) ? H_START_W : h_q + HW'(1);
      if (h_q == H_END_W) begin
        vdump_d    = line_inc(vdump_q);
        vrender_d  = line_inc(vrender_q);
        vrender1_d = line_inc(vrender1_q);
        if (vdump_q == V_END_W) begin
          frame_cnt_d = frame_cnt_q + 8'd1;
          hoff_d      = hoffset;
          voff_d      = voffset;
        end
      end
      hinit_d = (h_d == H_START_W);
      vinit_d = hinit_d && (vdump_d == V_START_W);
      hs_hit  = (h_d == hs_pos);

      if (hs_q) begin
        if (hs_cnt_q == 16'd0) hs_d = 1'b0;
        else                   hs_cnt_d = hs_cnt_q - 16'd1;
      end else if (hs_hit && HS_EN) begin
        hs_d     = 1'b1;
        hs_cnt_d = HS_LEN_M1;
      end

      if (vs_q) begin
        if (hs_hit) begin
          if (vs_cnt_q == 16'd0) vs_d = 1'b0;
          else                   vs_cnt_d = vs_cnt_q - 16'd1;
        end
      end else if (hs_hit && (vdump_d == vs_pos) && VS_EN) begin
        vs_d     = 1'b1;
        vs_cnt_d = VS_LEN_M1;
      end

      if (h_d == HB_START_W)    lhbl_d = 1'b0;
      else if (h_d == HB_END_W) lhbl_d = 1'b1;

      if (h_d == HB_START_W) begin
        if (vdump_d == VB_START_W)    lvbl_d = 1'b0;
        else if (vdump_d == VB_END_W) lvbl_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_q         <= H_START_W;
      vdump_q     <= V_START_W;
      vrender_q   <= V_START_W + HW'(1);
      vrender1_q  <= V_START_W + HW'(2);
      hinit_q     <= 1'b0;
      vinit_q     <= 1'b0;
      lhbl_q      <= 1'b0;
      lvbl_q      <= 1'b0;
      hs_q        <= 1'b0;
      hs_cnt_q    <= '0;
      vs_q        <= 1'b0;
      vs_cnt_q    <= '0;
      frame_cnt_q <= '0;
      hoff_q      <= '0;
      voff_q      <= '0;
    end else begin
      h_q         <= h_d;
      vdump_q     <= vdump_d;
      vrender_q   <= vrender_d;
      vrender1_q  <= vrender1_d;
      hinit_q     <= hinit_d;
      vinit_q     <= vinit_d;
      lhbl_q      <= lhbl_d;
      lvbl_q      <= lvbl_d;
      hs_q        <= hs_d;
      hs_cnt_q    <= hs_cnt_d;
      vs_q        <= vs_d;
      vs_cnt_q    <= vs_cnt_d;
      frame_cnt_q <= frame_cnt_d;
      hoff_q      <= hoff_d;
      voff_q      <= voff_d;
    end
  end

  assign pxl2_cen  = pxl2_cen_q;
  assign pxl_cen   = pxl_cen_q;
  assign H         = h_q;
  assign vdump     = vdump_q;
  assign vrender   = vrender_q;
  assign vrender1  = vrender1_q;
  assign Hinit     = hinit_q;
  assign Vinit     = vinit_q;
  assign LHBL      = lhbl_q;
  assign LVBL      = lvbl_q;
  assign HS        = hs_q;
  assign VS        = vs_q;
  assign frame_cnt = frame_cnt_q;
endmodule

// File: tb/tb_jtframe_vtimer_gen.sv
// Bench for jtframe_vtimer_gen: three instances (defaults, compact frame, N/M=1/3)
// compared every clock against a pixel-level reference model with random offsets.
module tb_jtframe_vtimer_gen;
  localparam int S_HE = 47, S_HBS = 31, S_HBE = 47, S_HSS = 36, S_HSL = 4;
  localparam int S_VS0 = 2, S_VE = 33, S_VBS = 29, S_VBE = 33, S_VSS = 31, S_VSL = 3;

  typedef struct {
    int n, m, hs0, he, hbs, hbe, hss, hsl, vs0, ve, vbs, vbe, vss, vsl;
  } geom_t;

  logic clk = 1'b0;
  logic rst_n;
  logic [2:0][3:0] hoff, voff;
  logic [2:0]      p2, px, hi, vi, lh, lv, hs, vs;
  logic [2:0][8:0] h_o, vd, vr, vr1;
  logic [2:0][7:0] fc;

  int n_cmp, n_bad;
  geom_t geo[3];
  int m_t[3], m_h[3], m_v[3], m_p[3], m_hst[3], m_vh[3], m_fc[3], m_hl[3], m_vl[3], d_p2[3];
  bit m_p2[3], m_px[3], m_hi[3], m_vi[3], m_lh[3], m_lv[3];

  always #5 clk = ~clk;

  jtframe_vtimer_gen u_dut0 (
    .clk(clk), .rst_n(rst_n), .hoffset(hoff[0]), .voffset(voff[0]),
    .pxl2_cen(p2[0]), .pxl_cen(px[0]), .H(h_o[0]), .vdump(vd[0]), .vrender(vr[0]),
    .vrender1(vr1[0]), .Hinit(hi[0]), .Vinit(vi[0]), .LHBL(lh[0]), .LVBL(lv[0]),
    .HS(hs[0]), .VS(vs[0]), .frame_cnt(fc[0]));

  jtframe_vtimer_gen #(
    .CEN_N(1), .CEN_M(2), .H_START(0), .H_END(S_HE), .HB_START(S_HBS), .HB_END(S_HBE),
    .HS_START(S_HSS), .HS_LEN(S_HSL), .V_START(S_VS0), .V_END(S_VE), .VB_START(S_VBS),
    .VB_END(S_VBE), .VS_START(S_VSS), .VS_LEN(S_VSL)
  ) u_dut1 (
    .clk(clk), .rst_n(rst_n), .hoffset(hoff[1]), .voffset(voff[1]),
    .pxl2_cen(p2[1]), .pxl_cen(px[1]), .H(h_o[1]), .vdump(vd[1]), .vrender(vr[1]),
    .vrender1(vr1[1]), .Hinit(hi[1]), .Vinit(vi[1]), .LHBL(lh[1]), .LVBL(lv[1]),
    .HS(hs[1]), .VS(vs[1]), .frame_cnt(fc[1]));

  jtframe_vtimer_gen #(.CEN_N(1), .CEN_M(3)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .hoffset(hoff[2]), .voffset(voff[2]),
    .pxl2_cen(p2[2]), .pxl_cen(px[2]), .H(h_o[2]), .vdump(vd[2]), .vrender(vr[2]),
    .vrender1(vr1[2]), .Hinit(hi[2]), .Vinit(vi[2]), .LHBL(lh[2]), .LVBL(lv[2]),
    .HS(hs[2]), .VS(vs[2]), .frame_cnt(fc[2]));

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic model_reset(input int i);
    m_t[i] = 0;  m_h[i] = geo[i].hs0;  m_v[i] = geo[i].vs0;  m_p[i] = 0;
    m_hst[i] = -(1 << 30);  m_vh[i] = geo[i].vsl;  m_fc[i] = 0;
    m_hl[i] = 0;  m_vl[i] = 0;  d_p2[i] = 0;
    m_p2[i] = 0;  m_px[i] = 0;  m_hi[i] = 0;  m_vi[i] = 0;  m_lh[i] = 0;  m_lv[i] = 0;
  endtask

  function automatic bit hs_on(input int i);
    return (m_p[i] - m_hst[i]) < geo[i].hsl;
  endfunction

  function automatic bit vs_on(input int i);
    return m_vh[i] < geo[i].vsl;
  endfunction

  // Line k ahead of the current one, wrapping inside the visible-count range
  function automatic int line_ahead(input int i, input int k);
    int nl;
    nl = geo[i].ve - geo[i].vs0 + 1;
    return ((m_v[i] - geo[i].vs0 + k) % nl) + geo[i].vs0;
  endfunction

  task automatic pixel_step(input int i);
    int hsp, vsp;
    bit hs_prev, vs_prev, hit, fwrap;
    hsp = (geo[i].hss + m_hl[i]) & 511;
    vsp = (geo[i].vss + m_vl[i]) & 511;
    hs_prev = hs_on(i);
    vs_prev = vs_on(i);
    fwrap = (m_h[i] == geo[i].he) && (m_v[i] == geo[i].ve);
    if (m_h[i] == geo[i].he) begin
      m_h[i] = geo[i].hs0;
      m_v[i] = line_ahead(i, 1);
    end else begin
      m_h[i]++;
    end
    m_p[i]++;
    if (fwrap) begin
      m_fc[i] = (m_fc[i] + 1) % 256;
      m_hl[i] = int'($signed(hoff[i]));
      m_vl[i] = int'($signed(voff[i]));
    end
    hit = (m_h[i] == hsp);
    if (!hs_prev && hit) m_hst[i] = m_p[i];
    if (vs_prev) begin
      if (hit) m_vh[i]++;
    end else if (hit && m_v[i] == vsp) begin
      m_vh[i] = 0;
    end
    if (m_h[i] == geo[i].hbs)      m_lh[i] = 0;
    else if (m_h[i] == geo[i].hbe) m_lh[i] = 1;
    if (m_h[i] == geo[i].hbs) begin
      if (m_v[i] == geo[i].vbs)      m_lv[i] = 0;
      else if (m_v[i] == geo[i].vbe) m_lv[i] = 1;
    end
    m_hi[i] = (m_h[i] == geo[i].hs0);
    m_vi[i] = m_hi[i] && (m_v[i] == geo[i].vs0);
  endtask

  // Enable k fires on the clock where floor(t*N/M) reaches k; every even k is a pixel
  task automatic model_edge(input int i);
    int kn, kp;
    bit step;
    step = m_px[i];
    m_t[i]++;
    kn = m_t[i] * geo[i].n / geo[i].m;
    kp = (m_t[i] - 1) * geo[i].n / geo[i].m;
    m_p2[i] = kn > kp;
    m_px[i] = m_p2[i] && (kn % 2 == 0);
    if (step) pixel_step(i);
  endtask

  function automatic logic [63:0] exp_vec(input int i);
    return {14'd0, 9'(m_h[i]), 9'(m_v[i]), 9'(line_ahead(i, 1)), 9'(line_ahead(i, 2)),
            m_hi[i], m_vi[i], m_lh[i], m_lv[i], hs_on(i), vs_on(i), 8'(m_fc[i])};
  endfunction

  function automatic logic [63:0] obs_vec(input int i);
    return {14'd0, h_o[i], vd[i], vr[i], vr1[i], hi[i], vi[i], lh[i], lv[i], hs[i], vs[i], fc[i]};
  endfunction

  task automatic compare_all();
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("i%0d_cen", i), 64'({p2[i], px[i]}), 64'({m_p2[i], m_px[i]}));
      chk($sformatf("i%0d_timing", i), obs_vec(i), exp_vec(i));
    end
  endtask

  task automatic run(input int n);
    for (int c = 0; c < n; c++) begin
      @(posedge clk);
      #1;
      for (int i = 0; i < 3; i++) model_edge(i);
      compare_all();
      if (vd[1] == 9'(S_VE)) begin
        chk("i1_wrap_vrender", 64'(vr[1]), 64'(S_VS0));
        chk("i1_wrap_vrender1", 64'(vr1[1]), 64'(S_VS0 + 1));
      end
      for (int i = 0; i < 3; i++) begin
        if (p2[i]) d_p2[i]++;
        if ($urandom_range(0, 299) == 0) hoff[i] = 4'($urandom);
        if ($urandom_range(0, 299) == 0) voff[i] = 4'($urandom);
      end
    end
  endtask

  initial begin
    int waited;
    n_cmp = 0;
    n_bad = 0;
    rst_n = 1'b0;
    hoff  = '0;
    voff  = '0;
    geo[0] = '{1, 4, 0, 383, 255, 383, 297, 32, 16, 279, 239, 279, 254, 3};
    geo[1] = '{1, 2, 0, S_HE, S_HBS, S_HBE, S_HSS, S_HSL, S_VS0, S_VE, S_VBS, S_VBE, S_VSS, S_VSL};
    geo[2] = '{1, 3, 0, 383, 255, 383, 297, 32, 16, 279, 239, 279, 254, 3};
    for (int i = 0; i < 3; i++) model_reset(i);

    repeat (3) @(posedge clk);
    #1;
    compare_all();
    chk("rst_H", 64'(h_o[0]), 64'd0);
    chk("rst_vdump", 64'(vd[0]), 64'd16);
    chk("rst_vrender", 64'(vr[0]), 64'd17);
    chk("rst_vrender1", 64'(vr1[0]), 64'd18);

    @(negedge clk) rst_n = 1'b1;
    run(20000);

    waited = 0;
    while (hs[1] !== 1'b1 && waited < 3000) begin
      run(1);
      waited++;
    end
    chk("hs_before_reset", 64'(hs[1]), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) model_reset(i);
    compare_all();
    chk("rst_async_hs", 64'(hs[1]), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    compare_all();
    @(negedge clk) rst_n = 1'b1;
    run(24000);

    for (int i = 0; i < 3; i++)
      chk($sformatf("i%0d_p2_count", i), 64'(d_p2[i]), 64'(m_t[i] * geo[i].n / geo[i].m));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
